// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath select codes and the bundled control-word type.
package mips_pkg;

    // Instruction opcodes (IR[31:26]) handled by the sequencer
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // FSM state encoding, also exported on dbg_state
    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_e;

    // ALUOp codes sent to the ALU control block
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B        = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_SEXT     = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // All datapath controls decoded from the current state
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // True for opcodes the sequencer knows how to execute
    function automatic logic op_is_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: legal = 1'b1;
            default:                                       legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/mips_mc_outdec.sv
// Moore output decoder: maps the current FSM state to the datapath control
// word. Only the memory-touching states look at mem_ready, so strobes that
// commit a memory transfer fire exactly once, on the completing cycle.
module mips_mc_outdec
    import mips_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    // Decode control word; every field defaults to 0 and is set per state
    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.i_or_d    = 1'b0;
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_a = 1'b0;
                ctrl_o.alu_src_b = SRCB_SEXT_SH2;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            MEMADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.reg_dst    = 1'b0;
            end
            MEMWR: begin
                ctrl_o.mem_write = mem_ready_i;
                ctrl_o.i_or_d    = 1'b1;
            end
            EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            RWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.mem_to_reg = 1'b0;
            end
            ADDIEX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_SEXT;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ADDIWB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b0;
            end
            BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_src_b     = SRCB_B;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JUMP;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: state register, next-state logic,
// illegal-opcode flag and retired-instruction counter. Output decoding lives
// in mips_mc_outdec; write strobes are additionally held low during reset.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int STATE_W = 4
) (
    input  logic               globalclock,
    input  logic               globalreset,
    input  logic [5:0]         opcode,
    input  logic               isZero,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   instr_count,
    output logic [STATE_W-1:0] dbg_state
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             retire;
    ctrl_t            ctrl;

    // The zero flag is consumed by the datapath together with PCWriteCond;
    // the sequencer itself never branches on it.
    logic unused_is_zero;
    assign unused_is_zero = isZero;

    mips_mc_outdec u_outdec (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // State and counter registers, cleared asynchronously by reset
    always_ff @(posedge globalclock or negedge globalreset) begin
        if (!globalreset) begin
            state_q <= FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state sequencing and retire detection on terminal states
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            FETCH: begin
                if (mem_ready) state_d = DECODE;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: begin
                if (opcode == OP_LW)      state_d = MEMRD;
                else if (opcode == OP_SW) state_d = MEMWR;
                else                      state_d = FETCH;
            end
            MEMRD: begin
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEMWR: begin
                if (mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            EXEC:   state_d = RWB;
            ADDIEX: state_d = ADDIWB;
            RWB, ADDIWB, BRANCH, JUMP: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Retired-instruction counter wraps naturally at all-ones
    always_comb begin
        count_d = count_q;
        if (retire) count_d = count_q + CNT_W'(1);
    end

    // Output drive: write strobes and illegal flag are gated by reset
    always_comb begin
        PCWrite     = globalreset & ctrl.pc_write;
        PCWriteCond = globalreset & ctrl.pc_write_cond;
        IRWrite     = globalreset & ctrl.ir_write;
        RegWrite    = globalreset & ctrl.reg_write;
        MemWrite    = globalreset & ctrl.mem_write;
        IorD        = ctrl.i_or_d;
        MemRead     = ctrl.mem_read;
        MemtoReg    = ctrl.mem_to_reg;
        RegDst      = ctrl.reg_dst;
        ALUSrcA     = ctrl.alu_src_a;
        ALUSrcB     = ctrl.alu_src_b;
        ALUOp       = ctrl.alu_op;
        PCSource    = ctrl.pc_source;
        illegal_op  = globalreset & (state_q == DECODE) & ~op_is_legal(opcode);
    end

    assign instr_count = count_q;
    assign dbg_state   = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for the multi-cycle controller. Each instruction is
// expanded into its expected per-cycle trace, queued, then replayed against
// the DUT. A second, narrow-counter instance exercises counter wrap.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       iz;
    logic       mr;

    logic        pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa;
    logic [1:0]  asb, aop, psrc;
    logic        ill;
    logic [31:0] cnt;
    logic [3:0]  dst;

    logic        s_pcw, s_pcwc, s_iord, s_mrd, s_mwr, s_irw, s_m2r, s_rdst, s_rwr, s_asa;
    logic [1:0]  s_asb, s_aop, s_psrc;
    logic        s_ill;
    logic [2:0]  s_cnt;
    logic [3:0]  s_dst;

    mips_multicycle_ctrl #(.CNT_W(32), .STATE_W(4)) dut (
        .globalclock(clk), .globalreset(rst_n), .opcode(op), .isZero(iz), .mem_ready(mr),
        .PCWrite(pcw), .PCWriteCond(pcwc), .IorD(iord), .MemRead(mrd), .MemWrite(mwr),
        .IRWrite(irw), .MemtoReg(m2r), .RegDst(rdst), .RegWrite(rwr), .ALUSrcA(asa),
        .ALUSrcB(asb), .ALUOp(aop), .PCSource(psrc), .illegal_op(ill),
        .instr_count(cnt), .dbg_state(dst)
    );

    mips_multicycle_ctrl #(.CNT_W(3), .STATE_W(4)) dut_w (
        .globalclock(clk), .globalreset(rst_n), .opcode(op), .isZero(iz), .mem_ready(mr),
        .PCWrite(s_pcw), .PCWriteCond(s_pcwc), .IorD(s_iord), .MemRead(s_mrd), .MemWrite(s_mwr),
        .IRWrite(s_irw), .MemtoReg(s_m2r), .RegDst(s_rdst), .RegWrite(s_rwr), .ALUSrcA(s_asa),
        .ALUSrcB(s_asb), .ALUOp(s_aop), .PCSource(s_psrc), .illegal_op(s_ill),
        .instr_count(s_cnt), .dbg_state(s_dst)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic        mr;
        logic        iz;
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic [31:0] cnt;
        logic [2:0]  scnt;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] cnt_m  = '0;
    logic [2:0]  scnt_m = '0;
    int          checks = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Control word order: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,
    // MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0]
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic m);
        logic pw = 0, pwc = 0, id = 0, rd = 0, wr = 0, ir = 0, mtr = 0, dst_r = 0, rw = 0, sa = 0;
        logic [1:0] sb = 2'b00, ao = 2'b00, ps = 2'b00;
        case (st)
            4'd0:  begin rd = 1; sb = 2'b01; ir = m; pw = m; end          // FETCH
            4'd1:  begin sb = 2'b11; end                                   // DECODE
            4'd2:  begin sa = 1; sb = 2'b10; end                           // MEMADR
            4'd3:  begin rd = 1; id = 1; end                               // MEMRD
            4'd4:  begin rw = 1; mtr = 1; end                              // MEMWB
            4'd5:  begin wr = m; id = 1; end                               // MEMWR
            4'd6:  begin sa = 1; ao = 2'b10; end                           // EXEC
            4'd7:  begin rw = 1; dst_r = 1; end                            // RWB
            4'd8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end      // BRANCH
            4'd9:  begin pw = 1; ps = 2'b10; end                           // JUMP
            4'd10: begin sa = 1; sb = 2'b10; end                           // ADDIEX
            4'd11: begin rw = 1; end                                       // ADDIWB
            default: ;
        endcase
        return {pw, pwc, id, rd, wr, ir, mtr, dst_r, rw, sa, sb, ao, ps};
    endfunction

    function automatic logic legal(input logic [5:0] o);
        return (o == 6'b000000) || (o == 6'b100011) || (o == 6'b101011) ||
               (o == 6'b000100) || (o == 6'b001000) || (o == 6'b000010);
    endfunction

    task automatic push(input logic [5:0] o, input logic [3:0] st, input logic m, input logic z);
        sb_t e;
        e.op = o; e.mr = m; e.iz = z; e.st = st;
        e.ctl  = exp_ctrl(st, m);
        e.ill  = (st == 4'd1) && !legal(o);
        e.cnt  = cnt_m;
        e.scnt = scnt_m;
        sb_q.push_back(e);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected cycle trace
    task automatic gen_instr(input logic [5:0] o, input int fw, input int mw, input logic z);
        for (int i = 0; i < fw; i++) push(o, 4'd0, 1'b0, z);
        push(o, 4'd0, 1'b1, z);
        push(o, 4'd1, rnd(), z);
        case (o)
            6'b100011: begin
                push(o, 4'd2, rnd(), z);
                for (int i = 0; i < mw; i++) push(o, 4'd3, 1'b0, z);
                push(o, 4'd3, 1'b1, z);
                push(o, 4'd4, rnd(), z);
            end
            6'b101011: begin
                push(o, 4'd2, rnd(), z);
                for (int i = 0; i < mw; i++) push(o, 4'd5, 1'b0, z);
                push(o, 4'd5, 1'b1, z);
            end
            6'b000000: begin push(o, 4'd6, rnd(), z); push(o, 4'd7, rnd(), z); end
            6'b001000: begin push(o, 4'd10, rnd(), z); push(o, 4'd11, rnd(), z); end
            6'b000100: push(o, 4'd8, rnd(), z);
            6'b000010: push(o, 4'd9, rnd(), z);
            default: ;
        endcase
        if (legal(o)) begin
            cnt_m++;
            scnt_m++;
        end
    endtask

    // Replay queued trace: drive just after posedge, compare on negedge
    task automatic run_queue();
        sb_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            op = e.op; mr = e.mr; iz = e.iz;
            @(negedge clk);
            check_eq("state", 64'(dst), 64'(e.st));
            check_eq("ctrl", 64'({pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa, asb, aop, psrc}),
                     64'(e.ctl));
            check_eq("illegal_op", 64'(ill), 64'(e.ill));
            check_eq("instr_count", 64'(cnt), 64'(e.cnt));
            check_eq("narrow_count", 64'(s_cnt), 64'(e.scnt));
            $display("cycle op=%b mr=%b state=%0d exp_state=%0d cnt=%0d scnt=%0d",
                     e.op, e.mr, dst, e.st, cnt, s_cnt);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_wstrobes"}, 64'({pcw, pcwc, irw, rwr, mwr}), 64'd0);
        check_eq({tag, "_state"}, 64'(dst), 64'd0);
        check_eq({tag, "_count"}, 64'(cnt), 64'd0);
        check_eq({tag, "_ncount"}, 64'(s_cnt), 64'd0);
        check_eq({tag, "_illegal"}, 64'(ill), 64'd0);
        $display("reset %s state=%0d cnt=%0d wstrobes=%b", tag, dst, cnt, {pcw, pcwc, irw, rwr, mwr});
    endtask

    initial begin
        rst_n = 1'b0; op = 6'b000000; iz = 1'b0; mr = 1'b1;
        // Reset with mem_ready high: FETCH must not raise IRWrite/PCWrite
        repeat (2) begin
            @(negedge clk);
            check_reset_state("reset");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        gen_instr(6'b000000, 0, 0, 1'b0);          // R-type, 4 cycles
        gen_instr(6'b100011, 2, 1, 1'b0);          // lw with waits, 8 cycles
        gen_instr(6'b000100, 0, 0, 1'b1);          // beq taken
        gen_instr(6'b000100, 0, 0, 1'b0);          // beq not taken
        gen_instr(6'b111111, 0, 0, 1'b0);          // illegal
        gen_instr(6'b001000, 1, 0, 1'b0);          // addi with fetch wait
        gen_instr(6'b101011, 0, 2, 1'b0);          // sw with write waits
        gen_instr(6'b000010, 0, 0, 1'b0);          // j: narrow counter now 7
        run_queue();
        check_eq("count_after_seq", 64'(cnt), 64'(cnt_m));
        check_eq("narrow_all_ones", 64'(s_cnt), 64'd7);

        // Abort a store stalled in MEMWR by reset
        push(6'b101011, 4'd0, 1'b1, 1'b0);
        push(6'b101011, 4'd1, 1'b1, 1'b0);
        push(6'b101011, 4'd2, 1'b0, 1'b0);
        push(6'b101011, 4'd5, 1'b0, 1'b0);
        run_queue();
        check_eq("abort_in_memwr", 64'(dst), 64'd5);
        rst_n = 1'b0;
        #1;
        check_reset_state("abort");
        mr = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_reset_state("abort_hold");
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt_m = '0; scnt_m = '0;

        // Wrap: seven random legal instructions, then j takes 7 -> 0
        for (int i = 0; i < 7; i++) begin
            case ($urandom_range(0, 4))
                0: gen_instr(6'b000000, 0, 0, 1'b0);
                1: gen_instr(6'b100011, 0, 0, 1'b0);
                2: gen_instr(6'b101011, 0, 0, 1'b0);
                3: gen_instr(6'b001000, 0, 0, 1'b0);
                default: gen_instr(6'b000100, 0, 0, rnd());
            endcase
        end
        run_queue();
        check_eq("pre_wrap", 64'(s_cnt), 64'd7);
        gen_instr(6'b000010, 0, 0, 1'b0);
        run_queue();
        @(negedge clk);
        check_eq("wrap_narrow", 64'(s_cnt), 64'd0);
        check_eq("wrap_wide", 64'(cnt), 64'd8);
        check_eq("wrap_state", 64'(dst), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
